id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have these ports, one clock, reset synchronous active-high:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold ID/EX contents
- flush  in  1  load bubble into ID/EX
- pc_d  in  32  decode-stage PC
- rs_addr_d, rt_addr_d, wa_d  in  5 each  source and destination register numbers
- rs_data_d, rt_data_d  in  32 each  register-file read values
- imm_d  in  32  extended immediate
- shamt_d  in  5  instruction shamt field
- aluop_d  in  4  ALU operation code (0..14)
- alusrc_d  in  1  1 = B operand from immediate
- regwe_d  in  1  instruction writes the register file
- fwd_m_we, fwd_w_we  in  1 each  MEM / WB stage write enable
- fwd_m_addr, fwd_w_addr  in  5 each  MEM / WB destination register
- fwd_m_data, fwd_w_data  in  32 each  MEM / WB result
- alu_a, alu_b  out  32 each  ALU operands A and B
- alu_s  out  5  ALU constant shift amount
- alu_op  out  4  ALU operation code
- rt_e  out  32  forwarded rt value, store data
- wa_e  out  5  EX destination register
- regwe_e  out  1  EX register write enable
- pc_e  out  32  EX PC
- valid_e  out  1  EX slot holds a real instruction

Function
REQ-002 Register fields SHALL be pc, rs_addr, rt_addr, wa, rs_data, rt_data, imm, shamt, aluop, alusrc, regwe, valid.
REQ-003 Update priority on each rising clk SHALL be: reset, then flush, then stall, then load.
REQ-004 On flush=1, all fields SHALL be zeroed and valid set to 0, whatever the value of stall.
REQ-005 On load (stall=0, flush=0), fields SHALL capture the *_d inputs and valid SHALL be set to 1.
REQ-006 On stall=1 with flush=0, fields SHALL hold, except rs_data and rt_data, which SHALL capture their forwarded values (REQ-008) so a WB result retiring during the stall is not lost.
REQ-007 All outputs SHALL be combinational from the register fields and the fwd_* inputs, with 0 cycles latency from register to output.
REQ-008 Forwarded rs value:
- fwd_m_data if fwd_m_we=1, fwd_m_addr=rs_addr and rs_addr!=0
- otherwise fwd_w_data if fwd_w_we=1, fwd_w_addr=rs_addr and rs_addr!=0
- otherwise rs_data
- The rt value SHALL follow the same rule using rt_addr.
- MEM SHALL take priority over WB when both match.
REQ-009 Operand outputs:
- alu_a = forwarded rs
- alu_b = imm if alusrc=1, else forwarded rt
- rt_e = forwarded rt, always
REQ-010 Pass-through outputs:
- alu_s = shamt
- alu_op = aluop
- wa_e = wa
- regwe_e = regwe AND valid
- pc_e = pc
- valid_e = valid
REQ-011 Register 0 SHALL never be forwarded; a stored rs_data/rt_data of 0 for address 0 SHALL pass unchanged.
REQ-012 aluop values 15 SHALL be passed through unmodified; the block performs no opcode checking.

Reset
REQ-013 reset=1 at a rising clk SHALL zero every field, overriding stall and flush.
REQ-014 Immediately after reset, all outputs SHALL be 0 when fwd_*_we=0.
REQ-015 Reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-016 With macro ID_EX_FWD_EN defined, the forwarding of REQ-006, REQ-008 and REQ-011 SHALL be compiled in.
REQ-017 Without ID_EX_FWD_EN:
- forwarded values SHALL equal the stored rs_data / rt_data.
- stall SHALL hold every field unchanged.
- fwd_* inputs SHALL be present in the port list and ignored.

Verification
REQ-018 Reset: reset=1 for 1 cycle, all *_d nonzero -> every output 0 and valid_e=0 on the next cycle.
REQ-019 Load, immediate operand: rs_data_d=5, imm_d=7, alusrc_d=1, aluop_d=0, no forwarding -> next cycle alu_a=5, alu_b=7, alu_op=0, valid_e=1.
REQ-020 Forward priority (ID_EX_FWD_EN defined):
- setup: rs_addr=3, fwd_m_addr=3 data 0x11, fwd_w_addr=3 data 0x22, both we=1 -> alu_a=0x11.
- then drop fwd_m_we -> alu_a=0x22.
- then set rs_addr=0 -> no forwarding.
REQ-021 Stall capture:
- setup: rt_addr=4, stall=1, fwd_w_addr=4 data 0xABCD with we=1 for 1 cycle, then fwd_w_we=0.
- with ID_EX_FWD_EN defined -> rt_e=0xABCD and all other fields unchanged.
- without ID_EX_FWD_EN -> rt_e keeps its old value.
REQ-022 Flush over stall: stall=1 and flush=1 in the same cycle -> valid_e=0, regwe_e=0, alu_op=0 on the next cycle.
REQ-023 Shift pass-through: shamt_d=31, aluop_d=12, rt_data_d=0x80000000, alusrc_d=0 -> alu_s=31, alu_b=0x80000000, alu_op=12.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding into the EX stage.
//   Holds the decoded instruction between decode and execute. The ALU operand
//   outputs are formed combinationally from the stored fields, so a result that
//   appears on the MEM or WB bypass buses in the current cycle reaches the ALU
//   without any added latency.
//
//   Configuration macro: ID_EX_FWD_EN
//     defined   : MEM/WB forwarding is built in. While stalled, the stored
//                 rs/rt data re-capture their forwarded values, so a WB result
//                 that retires during the stall is kept.
//     undefined : operands come straight from the stored register-file values,
//                 stall holds every field, and the fwd_* ports are ignored.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall, flush       hold the stage / load a bubble (flush wins over stall)
//   *_d                decode-stage instruction fields
//   fwd_m_*, fwd_w_*   MEM / WB bypass: write enable, destination, result
//   alu_a, alu_b       ALU operands (B is the immediate when alusrc is set)
//   alu_s, alu_op      constant shift amount and operation code
//   rt_e               forwarded rt value, used as store data
//   wa_e, regwe_e      EX destination register and write enable
//   pc_e, valid_e      EX PC and "slot holds a real instruction"
// -----------------------------------------------------------------------------
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] pc_d,
   input  logic [4:0]  rs_addr_d,
   input  logic [4:0]  rt_addr_d,
   input  logic [4:0]  wa_d,
   input  logic [31:0] rs_data_d,
   input  logic [31:0] rt_data_d,
   input  logic [31:0] imm_d,
   input  logic [4:0]  shamt_d,
   input  logic [3:0]  aluop_d,
   input  logic        alusrc_d,
   input  logic        regwe_d,
   input  logic        fwd_m_we,
   input  logic [4:0]  fwd_m_addr,
   input  logic [31:0] fwd_m_data,
   input  logic        fwd_w_we,
   input  logic [4:0]  fwd_w_addr,
   input  logic [31:0] fwd_w_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_s,
   output logic [3:0]  alu_op,
   output logic [31:0] rt_e,
   output logic [4:0]  wa_e,
   output logic        regwe_e,
   output logic [31:0] pc_e,
   output logic        valid_e
);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  wa;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [3:0]  aluop;
      logic        alusrc;
      logic        regwe;
      logic        valid;
   } idex_t;

   idex_t       q;
   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;

`ifdef ID_EX_FWD_EN
   // MEM is the younger result, so it is checked first. Register 0 is
   // hard-wired and is never taken from a bypass bus.
   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      fwd_rs = q.rs_data;
      fwd_rt = q.rt_data;
      if (q.rs_addr != 5'd0 && fwd_m_we && fwd_m_addr == q.rs_addr)
         fwd_rs = fwd_m_data;
      else if (q.rs_addr != 5'd0 && fwd_w_we && fwd_w_addr == q.rs_addr)
         fwd_rs = fwd_w_data;
      if (q.rt_addr != 5'd0 && fwd_m_we && fwd_m_addr == q.rt_addr)
         fwd_rt = fwd_m_data;
      else if (q.rt_addr != 5'd0 && fwd_w_we && fwd_w_addr == q.rt_addr)
         fwd_rt = fwd_w_data;
   end
`else
   assign fwd_rs = q.rs_data;
   assign fwd_rt = q.rt_data;

   // Bypass ports and stored register numbers have no function in this build.
   logic unused_fwd;
   assign unused_fwd = ^{fwd_m_we, fwd_m_addr, fwd_m_data,
                         fwd_w_we, fwd_w_addr, fwd_w_data,
                         q.rs_addr, q.rt_addr};
`endif

   // Priority: reset, flush, stall, load.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples its inputs from before the edge, independent of statement order.
      if (reset) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (!stall) begin
         q.pc      <= pc_d;
         q.rs_addr <= rs_addr_d;
         q.rt_addr <= rt_addr_d;
         q.wa      <= wa_d;
         q.rs_data <= rs_data_d;
         q.rt_data <= rt_data_d;
         q.imm     <= imm_d;
         q.shamt   <= shamt_d;
         q.aluop   <= aluop_d;
         q.alusrc  <= alusrc_d;
         q.regwe   <= regwe_d;
         q.valid   <= 1'b1;
      end
`ifdef ID_EX_FWD_EN
      else begin
         // The bypass buses move on during a stall; latch what they carry now.
         q.rs_data <= fwd_rs;
         q.rt_data <= fwd_rt;
      end
`endif
   end

   assign alu_a   = fwd_rs;
   assign alu_b   = q.alusrc ? q.imm : fwd_rt;
   assign rt_e    = fwd_rt;
   assign alu_s   = q.shamt;
   assign alu_op  = q.aluop;
   assign wa_e    = q.wa;
   assign regwe_e = q.regwe & q.valid;
   assign pc_e    = q.pc;
   assign valid_e = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Table-driven bench for id_ex_stage. Each record is one clock cycle: inputs
//   are driven on the falling edge, the expected outputs go onto a scoreboard
//   queue, and one step after the next rising edge the DUT outputs are compared
//   with the popped entry. Expectations that depend on forwarding follow the
//   ID_EX_FWD_EN macro. A short hand-written sequence at the end covers the
//   zero-latency path from bypass inputs to the operand outputs.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [31:0] pc_d, rs_data_d, rt_data_d, imm_d;
   logic [4:0]  rs_addr_d, rt_addr_d, wa_d, shamt_d;
   logic [3:0]  aluop_d;
   logic        alusrc_d, regwe_d;
   logic        fwd_m_we, fwd_w_we;
   logic [4:0]  fwd_m_addr, fwd_w_addr;
   logic [31:0] fwd_m_data, fwd_w_data;
   logic [31:0] alu_a, alu_b, rt_e, pc_e;
   logic [4:0]  alu_s, wa_e;
   logic [3:0]  alu_op;
   logic        regwe_e, valid_e;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .pc_d(pc_d), .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d), .wa_d(wa_d),
      .rs_data_d(rs_data_d), .rt_data_d(rt_data_d), .imm_d(imm_d),
      .shamt_d(shamt_d), .aluop_d(aluop_d), .alusrc_d(alusrc_d),
      .regwe_d(regwe_d),
      .fwd_m_we(fwd_m_we), .fwd_m_addr(fwd_m_addr), .fwd_m_data(fwd_m_data),
      .fwd_w_we(fwd_w_we), .fwd_w_addr(fwd_w_addr), .fwd_w_data(fwd_w_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_op(alu_op),
      .rt_e(rt_e), .wa_e(wa_e), .regwe_e(regwe_e), .pc_e(pc_e),
      .valid_e(valid_e)
   );

   typedef struct {
      logic        rst, stl, fls;
      logic [31:0] pc;
      logic [4:0]  rsa, rta, wa;
      logic [31:0] rsd, rtd, imm;
      logic [4:0]  sh;
      logic [3:0]  op;
      logic        src, we;
      logic        mwe;
      logic [4:0]  mad;
      logic [31:0] mdat;
      logic        wwe;
      logic [4:0]  wad;
      logic [31:0] wdat;
   } in_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  s;
      logic [3:0]  op;
      logic [31:0] rt;
      logic [4:0]  wa;
      logic        we;
      logic [31:0] pc;
      logic        v;
   } out_t;

   typedef struct {
      string name;
      in_t   i;
      out_t  e;
   } vec_t;

   vec_t  tab[$];
   out_t  sb[$];
   string sb_name[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   function automatic in_t quiet();
      in_t r;
      r.rst = 0; r.stl = 0; r.fls = 0;
      r.pc = 0; r.rsa = 0; r.rta = 0; r.wa = 0;
      r.rsd = 0; r.rtd = 0; r.imm = 0; r.sh = 0; r.op = 0;
      r.src = 0; r.we = 0;
      r.mwe = 0; r.mad = 0; r.mdat = 0;
      r.wwe = 0; r.wad = 0; r.wdat = 0;
      return r;
   endfunction

   // Nonzero decode fields; used where the stage must ignore them.
   function automatic in_t busy();
      in_t r;
      r = quiet();
      r.pc = 32'h100; r.rsa = 1; r.rta = 2; r.wa = 9;
      r.rsd = 32'h1111; r.rtd = 32'h2222; r.imm = 32'h33;
      r.sh = 3; r.op = 5; r.we = 1;
      return r;
   endfunction

   function automatic out_t mk(logic [31:0] a, logic [31:0] b, logic [4:0] s,
                               logic [3:0] op, logic [31:0] rt, logic [4:0] wa,
                               logic we, logic [31:0] pc, logic v);
      out_t r;
      r.a = a; r.b = b; r.s = s; r.op = op; r.rt = rt;
      r.wa = wa; r.we = we; r.pc = pc; r.v = v;
      return r;
   endfunction

   task automatic add(input string nm, input in_t i, input out_t e);
      vec_t t;
      t.name = nm; t.i = i; t.e = e;
      tab.push_back(t);
   endtask

   task automatic drive(input in_t v);
      reset = v.rst; stall = v.stl; flush = v.fls;
      pc_d = v.pc; rs_addr_d = v.rsa; rt_addr_d = v.rta; wa_d = v.wa;
      rs_data_d = v.rsd; rt_data_d = v.rtd; imm_d = v.imm;
      shamt_d = v.sh; aluop_d = v.op; alusrc_d = v.src; regwe_d = v.we;
      fwd_m_we = v.mwe; fwd_m_addr = v.mad; fwd_m_data = v.mdat;
      fwd_w_we = v.wwe; fwd_w_addr = v.wad; fwd_w_data = v.wdat;
   endtask

   task automatic check(input string nm, input out_t exp);
      out_t act;
      act = {alu_a, alu_b, alu_s, alu_op, rt_e, wa_e, regwe_e, pc_e, valid_e};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got a=%h b=%h s=%0d op=%0d rt=%h wa=%0d we=%b pc=%h v=%b, want a=%h b=%h s=%0d op=%0d rt=%h wa=%0d we=%b pc=%h v=%b",
                  nm, act.a, act.b, act.s, act.op, act.rt, act.wa, act.we, act.pc, act.v,
                  exp.a, exp.b, exp.s, exp.op, exp.rt, exp.wa, exp.we, exp.pc, exp.v);
      end
   endtask

   initial begin
      in_t  v;
      out_t z;
      out_t e_imm, e_fwd, e_cap;

      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset beats stall and flush; nonzero decode inputs are ignored.
      v = busy(); v.rst = 1; v.stl = 1; v.fls = 1;
      add("reset", v, z);

      v = quiet(); v.pc = 32'h40; v.rsa = 1; v.rta = 2; v.wa = 3;
      v.rsd = 5; v.rtd = 9; v.imm = 7; v.src = 1; v.op = 0; v.we = 1;
      e_imm = mk(5, 7, 0, 0, 9, 3, 1, 32'h40, 1);
      add("load_imm", v, e_imm);

      v = busy(); v.stl = 1;
      add("stall_hold", v, e_imm);

      v = busy();
      add("load_busy", v, mk(32'h1111, 32'h2222, 3, 5, 32'h2222, 9, 1, 32'h100, 1));

      v = busy(); v.stl = 1; v.fls = 1;
      add("flush_over_stall", v, z);

      v = quiet(); v.pc = 32'h200; v.rsa = 7; v.rta = 8; v.wa = 10;
      v.rsd = 32'h1234; v.rtd = 32'h8000_0000; v.imm = 32'hFFFF;
      v.sh = 31; v.op = 12; v.src = 0; v.we = 0;
      add("shift_pass", v, mk(32'h1234, 32'h8000_0000, 31, 12, 32'h8000_0000, 10, 0, 32'h200, 1));

      v.op = 15; v.we = 1;
      add("aluop_15", v, mk(32'h1234, 32'h8000_0000, 31, 15, 32'h8000_0000, 10, 1, 32'h200, 1));

      v = busy(); v.rst = 1; v.stl = 1;
      add("reset_mid_stall", v, z);

      v = busy(); v.stl = 1;
      add("post_reset_stall", v, z);

      // Forwarding: both stages match rs, MEM must win.
      v = quiet(); v.pc = 32'h300; v.rsa = 3; v.rta = 4; v.wa = 3;
      v.rsd = 5; v.rtd = 6; v.op = 1; v.we = 1;
      v.mwe = 1; v.mad = 3; v.mdat = 32'h11;
      v.wwe = 1; v.wad = 3; v.wdat = 32'h22;
      add("fwd_mem_prio", v, mk(FWD ? 32'h11 : 32'h5, 6, 0, 1, 6, 3, 1, 32'h300, 1));

      v = busy(); v.stl = 1;
      v.wwe = 1; v.wad = 3; v.wdat = 32'h22;
      e_fwd = mk(FWD ? 32'h22 : 32'h5, 6, 0, 1, 6, 3, 1, 32'h300, 1);
      add("fwd_wb_only", v, e_fwd);

      // Bypass gone; with forwarding the stall captured 0x22.
      v = busy(); v.stl = 1;
      add("fwd_captured", v, e_fwd);

      // Register 0 never forwarded; stored zero passes unchanged.
      v = quiet(); v.pc = 32'h304; v.rsa = 0; v.rta = 0; v.rsd = 5; v.rtd = 0;
      v.op = 2; v.we = 1;
      v.mwe = 1; v.mad = 0; v.mdat = 32'h11;
      v.wwe = 1; v.wad = 0; v.wdat = 32'h22;
      add("fwd_reg0", v, mk(5, 0, 0, 2, 0, 0, 1, 32'h304, 1));

      // Stall capture of a WB result that retires during the stall.
      v = quiet(); v.pc = 32'h400; v.rta = 4; v.rtd = 32'h77; v.wa = 5;
      v.op = 3; v.we = 1;
      add("cap_load", v, mk(0, 32'h77, 0, 3, 32'h77, 5, 1, 32'h400, 1));

      v = busy(); v.stl = 1;
      v.wwe = 1; v.wad = 4; v.wdat = 32'hABCD;
      e_cap = mk(0, FWD ? 32'hABCD : 32'h77, 0, 3, FWD ? 32'hABCD : 32'h77, 5, 1, 32'h400, 1);
      add("cap_stall", v, e_cap);

      v = busy(); v.stl = 1;
      add("cap_keep", v, e_cap);

      // rt forwarding with immediate B: B stays imm, rt_e forwards from MEM.
      v = quiet(); v.rta = 4; v.rtd = 1; v.imm = 5; v.src = 1;
      v.mwe = 1; v.mad = 4; v.mdat = 32'hAA;
      v.wwe = 1; v.wad = 4; v.wdat = 32'hBB;
      add("fwd_rt_imm", v, mk(0, 5, 0, 0, FWD ? 32'hAA : 32'h1, 0, 0, 0, 1));

      foreach (tab[k]) begin
         @(negedge clk);
         drive(tab[k].i);
         sb.push_back(tab[k].e);
         sb_name.push_back(tab[k].name);
         @(posedge clk);
         #1;
         check(sb_name.pop_front(), sb.pop_front());
      end

      // Bypass inputs reach the operands within the same cycle.
      @(negedge clk);
      v = quiet(); v.rsa = 3; v.rsd = 5; v.pc = 32'h500; v.wa = 7; v.we = 1;
      drive(v);
      @(posedge clk);
      #1;
      check("comb_before", mk(5, 0, 0, 0, 0, 7, 1, 32'h500, 1));
      #1;
      stall = 1; fwd_m_we = 1; fwd_m_addr = 3; fwd_m_data = 32'h99;
      #1;
      check("comb_fwd", mk(FWD ? 32'h99 : 32'h5, 0, 0, 0, 0, 7, 1, 32'h500, 1));
      fwd_m_we = 0;
      #1;
      check("comb_release", mk(5, 0, 0, 0, 0, 7, 1, 32'h500, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
